// File: rtl/adder_pkg.sv
// Shared configuration for the segmented pipelined ripple adder.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   DEF_WIDTH / DEF_SEG : default operand width and bits resolved per stage
//   calc_nstage()       : pipeline depth (= latency in cycles) for a config
//   cfg_ok()            : legality of a WIDTH/SEG pairing
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  // Number of pipeline stages; one stage per SEG-bit slice of the operands.
  // A non-positive segment width is mapped to depth 1 so this never divides by
  // zero; such a configuration is rejected separately by cfg_ok().
  function automatic int calc_nstage(input int width, input int seg);
    if (seg <= 0) begin
      return 1;
    end
    return width / seg;
  endfunction

  // Operand width must split into a whole number of non-empty segments.
  function automatic bit cfg_ok(input int width, input int seg);
    return (seg > 0) && (width > 0) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple-carry adder slice; one per pipeline stage.
// Latency: 0 cycles (pure combinational, holds no state).
// Backpressure: none; the enclosing pipeline decides when the result is kept.
//
// Ports:
//   a, b  : SEG-bit operand slices
//   ci    : carry into bit 0 of the slice
//   s     : SEG-bit sum slice
//   co    : carry out of the slice MSB
//   c_msb : carry into the slice MSB (the top slice uses it for signed overflow)
module rca_segment
  import adder_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  always_comb begin
    logic c;
    c     = ci;
    s     = '0;
    c_msb = ci;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) begin
        c_msb = c;
      end
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    co = c;
  end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined unsigned adder: each stage resolves one SEG-bit slice of A+B+cin.
// Latency: NSTAGE = WIDTH/SEG cycles from input handshake to out_valid, one beat per cycle.
// Backpressure: the whole pipe stalls when the output is held (out_valid && !out_ready); in_ready mirrors that.
//
// Ports:
//   clk, rst_n           : clock and synchronous active-low reset
//   in_valid / in_ready  : operand handshake (A, B, cin)
//   out_valid / out_ready: result handshake (sum, cout, finalsum, ovf)
//   sum / cout           : A+B+cin modulo 2^WIDTH and the carry out of bit WIDTH-1
//   finalsum             : {cout, sum}
//   ovf                  : two's-complement overflow (carry into MSB xor cout)
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH:0]   finalsum,
  output logic             ovf
);

  localparam int NSTAGE = calc_nstage(WIDTH, SEG);

  if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_check
    $error("pipelined_ripple_adder: WIDTH must be a positive multiple of SEG");
  end

  // Single global enable: the pipe moves only when the final result register
  // is empty or being consumed. There are no per-stage bubbles to squeeze, so
  // every stage shares this enable and in-order delivery is automatic.
  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage k adds operand slice k. Its operand source is the raw input for
  // k=0, otherwise the skew registers of stage k-1, whose low SEG bits are
  // exactly slice k. Each stage keeps only the operand bits still unresolved
  // (skew) and the sum bits already resolved (deskew), so register widths
  // shrink/grow by SEG per stage and no dead bits exist.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int SRC_W = WIDTH - k * SEG;     // operand bits still to add
    localparam int SUM_W = (k + 1) * SEG;       // sum bits resolved after this stage

    logic [SRC_W-1:0] a_src;
    logic [SRC_W-1:0] b_src;
    logic             c_src;
    logic             vld_src;

    logic [SEG-1:0]   seg_s;
    logic             seg_co;
    logic             seg_cmsb;

    logic [SUM_W-1:0] sum_d;
    logic [SUM_W-1:0] sum_q;
    logic             carry_q;
    logic             vld_q;

    if (k == 0) begin : g_head
      assign a_src   = A;
      assign b_src   = B;
      assign c_src   = cin;
      assign vld_src = in_valid;
      assign sum_d   = seg_s;
    end else begin : g_body
      assign a_src   = g_stage[k-1].g_skew.a_q;
      assign b_src   = g_stage[k-1].g_skew.b_q;
      assign c_src   = g_stage[k-1].carry_q;
      assign vld_src = g_stage[k-1].vld_q;
      // New slice goes on top of the already-resolved lower bits.
      assign sum_d   = {seg_s, g_stage[k-1].sum_q};
    end

    rca_segment #(
      .SEG (SEG)
    ) u_seg (
      .a     (a_src[SEG-1:0]),
      .b     (b_src[SEG-1:0]),
      .ci    (c_src),
      .s     (seg_s),
      .co    (seg_co),
      .c_msb (seg_cmsb)
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q   <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        vld_q   <= vld_src;
        carry_q <= seg_co;
        sum_q   <= sum_d;
      end
    end

    // Operand bits above this slice ride along to the next stage.
    if (k < NSTAGE - 1) begin : g_skew
      logic [SRC_W-SEG-1:0] a_q;
      logic [SRC_W-SEG-1:0] b_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_src[SRC_W-1:SEG];
          b_q <= b_src[SRC_W-1:SEG];
        end
      end
    end

    // Only the top slice sees the operand MSB, so overflow is formed here
    // and registered alongside the final sum and carry.
    if (k == NSTAGE - 1) begin : g_tail
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= seg_cmsb ^ seg_co;
        end
      end
    end else begin : g_mid
      // Carry into a lower slice's MSB has no meaning for the result.
      logic cmsb_unused;
      assign cmsb_unused = seg_cmsb;
    end
  end

  assign out_valid = g_stage[NSTAGE-1].vld_q;
  assign sum       = g_stage[NSTAGE-1].sum_q;
  assign cout      = g_stage[NSTAGE-1].carry_q;
  assign ovf       = g_stage[NSTAGE-1].g_tail.ovf_q;
  assign finalsum  = {cout, sum};

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder (WIDTH=16, SEG=4).
// Latency: directed beats check exact NSTAGE-cycle timing.
// Backpressure: stalls are driven from fixed and random out_ready patterns.
module tb_pipelined_ripple_adder;

  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         cin       = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a_in      = '0;
  logic [W-1:0] b_in      = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic [W:0]   finalsum;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  int pushes   = 0;
  int pops     = 0;

  // Expected results in acceptance order: {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];

  pipelined_ripple_adder #(.WIDTH(W), .SEG(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .finalsum  (finalsum),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Overflow means the signed sum does
  // not fit in W-bit two's complement.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    longint full, sa, sb, ssum, lim;
    logic   o;
    full = longint'(a) + longint'(b) + longint'(c);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ssum = sa + sb + longint'(c);
    lim  = longint'(1) <<< (W - 1);
    o    = (ssum > lim - 1) || (ssum < -lim);
    return {o, full[W:0]};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(7))
      0:       return '1;
      1:       return '0;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples mid-cycle, when inputs and outputs are both settled and
  // reflect what the next rising edge will see.
  initial begin
    logic         prev_stall;
    logic [W+1:0] prev_out;
    logic [W:0]   prev_fs;
    logic [W+1:0] e;
    prev_stall = 1'b0;
    prev_out   = '0;
    prev_fs    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'(1));
          chk("stall_hold", 64'({ovf, cout, sum}), 64'(prev_out));
          chk("stall_finalsum", 64'(finalsum), 64'(prev_fs));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got %h expected no result", {ovf, cout, sum});
          end else begin
            e = exp_q.pop_front();
            chk("result", 64'({ovf, cout, sum}), 64'(e));
            chk("result_finalsum", 64'(finalsum), 64'(e[W:0]));
          end
          pops++;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a_in, b_in, cin));
          pushes++;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {ovf, cout, sum};
        prev_fs    = finalsum;
      end
    end
  end

  // One isolated beat into an empty pipe with a hand-computed expectation.
  task automatic single_beat(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input logic [W-1:0] es, input logic ec,
                             input logic eo);
    a_in      = a;
    b_in      = b;
    cin       = c;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= N; i++) begin
      step();
      in_valid = 1'b0;
      chk($sformatf("%s_latency_valid%0d", name, i), 64'(out_valid), 64'(i == N));
    end
    chk($sformatf("%s_sum", name), 64'(sum), 64'(es));
    chk($sformatf("%s_cout", name), 64'(cout), 64'(ec));
    chk($sformatf("%s_ovf", name), 64'(ovf), 64'(eo));
    chk($sformatf("%s_finalsum", name), 64'(finalsum), 64'({ec, es}));
    step();
    chk($sformatf("%s_drained", name), 64'(out_valid), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ba[3];
    logic [W-1:0] bb[3];
    logic [W-1:0] bs[3];
    int           pat[7];
    int           start;
    int           cyc;
    int           j;
    int           pidx;
    logic         started;
    logic         took;

    ba  = '{16'h000C, 16'h000D, 16'h0006};
    bb  = '{16'h000F, 16'h000D, 16'h0009};
    bs  = '{16'h001B, 16'h001A, 16'h000F};
    pat = '{1, 0, 0, 1, 0, 1, 1};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_finalsum", 64'(finalsum), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", 64'(in_ready), 64'(1));
    step();

    // Single beats, carry chain across every slice, wrap-around, overflow.
    single_beat("basic", 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);
    single_beat("chain", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    single_beat("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    single_beat("wrap", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    single_beat("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Back-to-back beats emerge on consecutive cycles at latency N.
    out_ready = 1'b1;
    for (int i = 0; i < N + 3; i++) begin
      if (i < 3) begin
        a_in     = ba[i];
        b_in     = bb[i];
        cin      = 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= N - 1 && i < N + 2) begin
        chk("b2b_valid", 64'(out_valid), 64'(1));
        chk("b2b_sum", 64'(sum), 64'(bs[i-(N-1)]));
      end else begin
        chk("b2b_idle", 64'(out_valid), 64'(0));
      end
    end

    // Backpressure: 6 beats, out_ready pattern starts with the first result.
    start     = pops;
    cyc       = 0;
    j         = 0;
    pidx      = 0;
    started   = 1'b0;
    out_ready = 1'b1;
    while ((pops - start) < 6 && cyc < 200) begin
      in_valid = (j < 6);
      a_in     = rand_operand();
      b_in     = rand_operand();
      cin      = 1'($urandom_range(1));
      if (out_valid) begin
        started = 1'b1;
      end
      if (started) begin
        out_ready = (pidx < 7) ? (pat[pidx] != 0) : 1'b1;
        pidx++;
      end
      #1;
      if (out_valid && !out_ready) begin
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
      end
      took = in_valid && in_ready;
      step();
      if (took) begin
        j++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 64'(pops - start), 64'(6));
    chk("bp_inflight", 64'(exp_q.size()), 64'(0));
    step();

    // Reset mid-flight discards three accepted beats.
    for (int i = 0; i < 3; i++) begin
      a_in     = rand_operand();
      b_in     = rand_operand();
      cin      = 1'($urandom_range(1));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_sum", 64'(sum), 64'(0));
    chk("midrst_finalsum", 64'(finalsum), 64'(0));
    chk("midrst_ovf", 64'(ovf), 64'(0));
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 8; i++) begin
      step();
      chk("midrst_quiet", 64'(out_valid), 64'(0));
    end
    single_beat("post_rst", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

    // Random traffic with random stalls, scored by the monitor.
    start = pushes;
    cyc   = 0;
    while ((pushes - start) < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a_in      = rand_operand();
      b_in      = rand_operand();
      cin       = 1'($urandom_range(1));
      step();
      cyc++;
    end
    chk("rand_accepted", 64'((pushes - start) >= 10000), 64'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc       = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("rand_drained", 64'(exp_q.size()), 64'(0));
    repeat (2) step();
    chk("rand_final_idle", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_ripple_adder.md
PIPELINED_RIPPLE_ADDER -- requirements
Module: pipelined_ripple_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits.
REQ-002 Parameter SEG, default 4: bits resolved per pipeline stage; WIDTH SHALL be an integer multiple of SEG, and elaboration SHALL fail otherwise.
REQ-003 Derived constant NSTAGE = WIDTH/SEG: pipeline depth and latency in cycles.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  pipeline accepts a beat this cycle.
REQ-008 A  input  WIDTH  operand A, unsigned.
REQ-009 B  input  WIDTH  operand B, unsigned.
REQ-010 cin  input  1  carry into bit 0.
REQ-011 out_valid  output  1  result beat held.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of bit WIDTH-1.
REQ-015 finalsum  output  WIDTH+1  {cout, sum}.
REQ-016 ovf  output  1  two's-complement overflow: carry into MSB XOR cout.

Function
REQ-017 A beat SHALL transfer in when in_valid && in_ready, and out when out_valid && out_ready.
REQ-018 The global advance signal SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv, combinationally.
REQ-019 When adv=0, every stage register SHALL hold its value.
REQ-020 When adv=1, stage k (0..NSTAGE-1) SHALL add segment k of its operands plus the carry registered by stage k-1 (cin for k=0), and register that sum segment together with the carry out.
REQ-021 Operand segments above k SHALL be carried forward in skew registers; completed lower sum segments SHALL be carried forward in deskew registers, so that all bits of a result emerge aligned.
REQ-022 Each stage SHALL carry a valid bit; a bubble (in_valid=0 while adv=1) SHALL propagate as valid=0.
REQ-023 Latency SHALL be exactly NSTAGE cycles from input handshake to out_valid=1 while out_ready remains 1; one beat per cycle SHALL be sustained.
REQ-024 Results SHALL leave in input order; no beat SHALL be dropped or duplicated under any out_ready pattern.
REQ-025 out_valid, sum, cout, finalsum and ovf SHALL be registered outputs of the last stage and SHALL remain stable while out_valid && !out_ready.
REQ-026 Wrap-around: all-ones + all-ones + cin=1 SHALL give sum = all-ones and cout=1.
REQ-027 When NSTAGE=1, the block SHALL behave as a single registered adder with latency 1.

Reset
REQ-028 While rst_n=0 at a clock edge, all stage valid bits SHALL clear, and out_valid, sum, cout, finalsum and ovf SHALL become 0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no result from before reset SHALL appear afterwards.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-031 Package adder_pkg SHALL hold the default WIDTH and SEG values and a function computing NSTAGE.
REQ-032 Sub-module rca_segment SHALL be a combinational SEG-bit ripple adder (a, b, ci -> s, co, c_msb), instantiated once per stage; c_msb is the carry into the segment MSB and is used for ovf in the last stage.
REQ-033 All registers SHALL be in the top module; rca_segment SHALL contain no state.

Verification (WIDTH=16, SEG=4)
REQ-034 Single beat: A=0x0002, B=0x0003, cin=0, out_ready=1 -> exactly 4 cycles later out_valid=1, sum=0x0005, cout=0, finalsum=0x00005.
REQ-035 Carry chain across all stages: A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0; then A=0x7FFF, B=0x0001, cin=0 -> sum=0x8000, ovf=1.
REQ-036 Back-to-back beats: 0x000C+0x000F, 0x000D+0x000D, 0x0006+0x0009 on consecutive cycles -> 0x001B, 0x001A, 0x000F on consecutive cycles starting at latency 4.
REQ-037 Backpressure: 6 beats streamed with out_ready pattern 1,0,0,1,0,1,1,... -> all 6 results in order, outputs stable during stalls, and in_ready=0 whenever out_valid && !out_ready.
REQ-038 Reset mid-flight: 3 beats accepted, rst_n=0 for 1 cycle at cycle 2 -> out_valid stays 0 until a new beat is accepted, and that beat's result appears 4 cycles later.
REQ-039 Random: 10k beats with random A, B, cin, in_valid and out_ready -> scoreboard matches {cout,sum} = A+B+cin and ovf for every beat.
